sum_accum_serializer: RTL and testbench
=======================================

SUM_ACCUM_SERIALIZER -- requirements
Module: sum_accum_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 7: bit width of the adder sum input.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: accumulator width; SHALL be a multiple of 8 and at least WIDTH+1.
REQ-003 SHALL have parameter COUNT, default 8: number of accepted samples per burst, range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s  input  WIDTH  sum from the upstream carry-look-ahead adder.
REQ-007 c  input  1  carry-out from the upstream carry-look-ahead adder.
REQ-008 in_valid  input  1  {c,s} is a valid sample this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 flush  input  1  end the burst early and emit the accumulator.
REQ-011 out_byte  output  8  current output byte.
REQ-012 out_valid  output  1  out_byte is valid.
REQ-013 out_ready  input  1  consumer accepts out_byte this cycle.
REQ-014 out_last  output  1  out_byte is the final byte of the burst.
REQ-015 ovf  output  1  sticky accumulator overflow for the current burst.

Function
REQ-016 SHALL implement a two-state FSM: ACCUM and DRAIN.
REQ-017 ACCUM: in_ready=1, out_valid=0; in_valid=1 is an accepted sample.
REQ-018 Accepted sample: acc <= (acc + zero-extended {c,s}) mod 2^ACC_WIDTH; sample count increments by 1.
REQ-019 Accumulator carry-out SHALL set ovf; ovf holds until the burst drains or reset.
REQ-020 ACCUM->DRAIN SHALL occur at the posedge where the accepted sample brings the count to COUNT, or where flush=1, whichever comes first.
REQ-021 in_valid=1 and flush=1 in the same ACCUM cycle: the sample SHALL be accumulated and the state SHALL then move to DRAIN.
REQ-022 flush=1 with count=0 and no sample: SHALL still drain, emitting a zero accumulator.
REQ-023 DRAIN: in_ready=0; in_valid and flush SHALL be ignored; the accumulator SHALL be frozen.
REQ-024 DRAIN SHALL present ACC_WIDTH/8 bytes, least-significant byte first: out_byte=acc[8k+7:8k] for byte index k; out_valid=1.
REQ-025 Each byte SHALL stay stable until the cycle where out_valid && out_ready; k then increments at that posedge.
REQ-026 out_last SHALL be 1 exactly while k = ACC_WIDTH/8-1 in DRAIN.
REQ-027 Handshake on the last byte SHALL, at the same posedge: clear acc, count, k and ovf; return to ACCUM.
REQ-028 Latency: the first byte SHALL be valid the cycle after the terminating sample or flush; in_ready SHALL reassert the cycle after the last-byte handshake.
REQ-029 No combinational path SHALL exist from any input to in_ready, out_valid, out_byte or out_last; all are derived from registered state.

Reset
REQ-030 rst=1 SHALL immediately and asynchronously force: state=ACCUM, acc=0, count=0, k=0, ovf=0, in_ready=1, out_valid=0, out_byte=0, out_last=0.
REQ-031 Reset mid-burst or mid-drain SHALL discard all partial state with no output of remaining bytes; normal operation SHALL resume on the first posedge after rst deasserts.

Verification
REQ-032 Eight samples {c,s}=0x05, out_ready=1 -> bytes 0x28 then 0x00, out_last on the second byte, ovf=0.
REQ-033 Samples 0xFF, 0xFF, then flush with out_ready=0 for 3 cycles -> out_byte=0xFE held stable with out_valid=1; then 0xFE, 0x01; in_ready=0 throughout.
REQ-034 in_valid=1 with {c,s}=0x10 and flush=1 in the same cycle, count=2, acc=0x0003 -> bytes 0x13, 0x00.
REQ-035 Preload to 0xFFF0 by ordered samples, then sample 0x20 -> acc=0x0010 and ovf=1; ovf clears after the last-byte handshake.
REQ-036 rst asserted during the first drained byte -> out_valid drops without a clock edge; after release in_ready=1 and the next burst starts from acc=0.
REQ-037 in_valid pulses during DRAIN -> not accumulated; burst output unchanged.

Source files
------------

// File: rtl/sum_accum_serializer.sv
// Accumulates {carry, sum} samples from an upstream adder over a burst, then
// serializes the accumulator LSB-first as bytes with a valid/ready handshake.
module sum_accum_serializer #(
    parameter int WIDTH     = 7,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic             c,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             ovf
);

    localparam int NBYTES = ACC_WIDTH / 8;
    localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW     = ACC_WIDTH + 1;

    localparam logic [KW-1:0] K_LAST     = KW'(NBYTES - 1);
    localparam logic [3:0]    COUNT_LAST = 4'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [3:0]             count_q, count_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH:0]     sum_ext;
    logic [ACC_WIDTH-1:0]   acc_shift;

    // Extra top bit captures the accumulator carry-out for overflow detection.
    assign sum_ext   = {1'b0, acc_q} + SW'({c, s});
    assign acc_shift = acc_q >> {k_q, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        k_d       = k_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = sum_ext[ACC_WIDTH-1:0];
                    count_d = count_q + 4'd1;
                    if (sum_ext[ACC_WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                end
                // A sample arriving together with flush is still accumulated.
                if ((in_valid && (count_q == COUNT_LAST)) || flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_byte  = acc_shift[7:0];
                out_last  = (k_q == K_LAST);
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        k_d     = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_sum_accum_serializer.sv
// Directed bench for sum_accum_serializer: a vector table on the default
// configuration plus hand sequences for async reset and accumulator overflow.
module tb_sum_accum_serializer;

    logic       clk = 1'b0;
    logic       rst;

    logic [6:0] s;
    logic       c;
    logic       in_valid, flush, out_ready;
    logic       in_ready, out_valid, out_last, ovf;
    logic [7:0] out_byte;

    logic [14:0] s_b;
    logic        c_b;
    logic        in_valid_b, flush_b, out_ready_b;
    logic        in_ready_b, out_valid_b, out_last_b, ovf_b;
    logic [7:0]  out_byte_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accum_serializer #(.WIDTH(7), .ACC_WIDTH(16), .COUNT(8)) dut (
        .clk(clk), .rst(rst), .s(s), .c(c), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .ovf(ovf)
    );

    sum_accum_serializer #(.WIDTH(15), .ACC_WIDTH(16), .COUNT(15)) dut_b (
        .clk(clk), .rst(rst), .s(s_b), .c(c_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .flush(flush_b), .out_byte(out_byte_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .ovf(ovf_b)
    );

    typedef struct {
        logic [7:0] cs;
        logic       vld;
        logic       fl;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_byte;
        logic       e_last;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] cs, input logic vld, input logic fl,
                                input logic ordy, input logic e_rdy, input logic e_ov,
                                input logic [7:0] e_byte, input logic e_last, input logic e_ovf);
        vec_t v;
        v.cs = cs; v.vld = vld; v.fl = fl; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_byte = e_byte; v.e_last = e_last; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic e_rdy, input logic e_ov,
                           input logic [7:0] e_byte, input logic e_last, input logic e_ovf);
        check({tag, ".in_ready"},  int'(in_ready),  int'(e_rdy));
        check({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
        check({tag, ".out_byte"},  int'(out_byte),  int'(e_byte));
        check({tag, ".out_last"},  int'(out_last),  int'(e_last));
        check({tag, ".ovf"},       int'(ovf),       int'(e_ovf));
    endtask

    task automatic check_b(input string tag, input logic e_rdy, input logic e_ov,
                           input logic [7:0] e_byte, input logic e_last, input logic e_ovf);
        check({tag, ".in_ready"},  int'(in_ready_b),  int'(e_rdy));
        check({tag, ".out_valid"}, int'(out_valid_b), int'(e_ov));
        check({tag, ".out_byte"},  int'(out_byte_b),  int'(e_byte));
        check({tag, ".out_last"},  int'(out_last_b),  int'(e_last));
        check({tag, ".ovf"},       int'(ovf_b),       int'(e_ovf));
    endtask

    // Drive one cycle of inputs on dut at the falling edge, then compare.
    task automatic step_a(input string tag, input logic [7:0] cs, input logic vld, input logic fl,
                          input logic ordy, input logic e_rdy, input logic e_ov,
                          input logic [7:0] e_byte, input logic e_last, input logic e_ovf);
        @(negedge clk);
        {c, s} = cs; in_valid = vld; flush = fl; out_ready = ordy;
        #1;
        check_a(tag, e_rdy, e_ov, e_byte, e_last, e_ovf);
    endtask

    task automatic step_b(input string tag, input logic [15:0] cs, input logic vld, input logic fl,
                          input logic ordy, input logic e_rdy, input logic e_ov,
                          input logic [7:0] e_byte, input logic e_last, input logic e_ovf);
        @(negedge clk);
        {c_b, s_b} = cs; in_valid_b = vld; flush_b = fl; out_ready_b = ordy;
        #1;
        check_b(tag, e_rdy, e_ov, e_byte, e_last, e_ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {c, s} = 8'h00; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        {c_b, s_b} = 16'h0000; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b0;
        #1;
        check_a("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_b("reset_b", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Eight samples of 0x05 terminate the burst by count.
        for (int i = 0; i < 8; i++) vecs.push_back(mk(8'h05, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h28, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        // 0xFF + 0xFF, flush, consumer stalls for three cycles.
        vecs.push_back(mk(8'hFF, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(8'h00, 0, 0, 0, 0, 1, 8'hFE, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'hFE, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h01, 1, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        // acc=3 after two samples, then sample 0x10 together with flush.
        vecs.push_back(mk(8'h01, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h02, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h10, 1, 1, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h13, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        // Samples and flushes during drain are ignored.
        vecs.push_back(mk(8'h07, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h55, 1, 1, 0, 0, 1, 8'h07, 0, 0));
        vecs.push_back(mk(8'h55, 1, 0, 1, 0, 1, 8'h07, 0, 0));
        vecs.push_back(mk(8'h55, 1, 1, 1, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0));
        // Flush on an empty burst drains a zero accumulator.
        vecs.push_back(mk(8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            step_a($sformatf("vec%0d", i), vecs[i].cs, vecs[i].vld, vecs[i].fl, vecs[i].ordy,
                   vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_byte, vecs[i].e_last, vecs[i].e_ovf);
        end

        // Asynchronous reset in the middle of the first drained byte.
        step_a("rst_burst", 8'h09, 1, 1, 0, 1, 0, 8'h00, 0, 0);
        step_a("rst_drain", 8'h00, 0, 0, 0, 0, 1, 8'h09, 0, 0);
        #1 rst = 1'b1;
        #1;
        check_a("rst_async", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step_a("rst_resume0", 8'h03, 1, 1, 0, 1, 0, 8'h00, 0, 0);
        step_a("rst_resume1", 8'h00, 0, 0, 1, 0, 1, 8'h03, 0, 0);
        step_a("rst_resume2", 8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0);
        step_a("rst_resume3", 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);

        // Overflow on the wide-sample instance: 0xFFF0 + 0x20 wraps to 0x0010.
        step_b("ovf_s0", 16'hFFF0, 1, 0, 0, 1, 0, 8'h00, 0, 0);
        step_b("ovf_s1", 16'h0020, 1, 0, 0, 1, 0, 8'h00, 0, 0);
        step_b("ovf_s2", 16'h0000, 1, 0, 0, 1, 0, 8'h00, 0, 1);
        step_b("ovf_fl", 16'h0000, 0, 1, 0, 1, 0, 8'h00, 0, 1);
        step_b("ovf_d0", 16'h0000, 0, 0, 1, 0, 1, 8'h10, 0, 1);
        step_b("ovf_d1", 16'h0000, 0, 0, 1, 0, 1, 8'h00, 1, 1);
        step_b("ovf_clr", 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        // A fresh small burst confirms the accumulator restarted from zero.
        step_b("ovf_nx0", 16'h0123, 1, 1, 0, 1, 0, 8'h00, 0, 0);
        step_b("ovf_nx1", 16'h0000, 0, 0, 1, 0, 1, 8'h23, 0, 0);
        step_b("ovf_nx2", 16'h0000, 0, 0, 1, 0, 1, 8'h01, 1, 0);
        step_b("ovf_nx3", 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
